// File: rtl/input_pkg.sv
// Shared definitions for the pin conditioning front end and the IRQ controller.
package input_pkg;

    localparam int unsigned N_BUTTONS  = 4;
    localparam int unsigned N_SWITCHES = 10;

    localparam logic BTN_IDLE = 1'b1;
    localparam logic SW_IDLE  = 1'b0;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

endpackage

// File: rtl/input_debouncer_channel.sv
// One debounced pin: 2-FF synchroniser, tick-driven stability counter, output register.
module debounce_channel #(
    parameter logic        RESET_VAL    = 1'b0,
    parameter int unsigned STABLE_TICKS = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic din_raw,
    input  logic tick,
    input  logic run,
    input  logic prime,
    output logic q
);

    localparam int unsigned CW = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= RESET_VAL;
            sync2 <= RESET_VAL;
            q     <= RESET_VAL;
            cnt   <= '0;
        end else begin
            sync1 <= din_raw;
            sync2 <= sync1;
            if (prime) begin
                q   <= sync2;
                cnt <= '0;
            end else if (!run || sync2 == q) begin
                // any matching sample throws away accumulated progress
                cnt <= '0;
            end else if (tick) begin
                if (cnt == CW'(STABLE_TICKS - 1)) begin
                    q   <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/input_debouncer.sv
// Debounces DE-board KEY/SW pins; primes outputs from real pin state after reset.
module input_debouncer #(
    parameter int unsigned N_BUTTONS    = input_pkg::N_BUTTONS,
    parameter int unsigned N_SWITCHES   = input_pkg::N_SWITCHES,
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned STABLE_TICKS = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_BUTTONS-1:0]  btn_raw,
    input  logic [N_SWITCHES-1:0] sw_raw,
    output logic [N_BUTTONS-1:0]  buttons,
    output logic [N_SWITCHES-1:0] switches,
    output logic                  ready
);

    import input_pkg::*;

    localparam int unsigned PW = $clog2(TICK_DIV);

    logic [PW-1:0] presc;
    logic          tick;
    state_t        state;
    logic          fill_cnt;
    logic          run;
    logic          prime;

    assign tick  = (presc == PW'(TICK_DIV - 1));
    assign run   = (state == ST_RUN);
    assign prime = (state == ST_PRIME);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // two fill edges let the synchronisers see real pin state before priming
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_FILL;
            fill_cnt <= 1'b0;
            ready    <= 1'b0;
        end else begin
            case (state)
                ST_FILL: begin
                    fill_cnt <= fill_cnt + 1'b1;
                    if (fill_cnt) state <= ST_PRIME;
                end
                ST_PRIME: begin
                    ready <= 1'b1;
                    state <= ST_RUN;
                end
                ST_RUN:  state <= ST_RUN;
                default: state <= ST_FILL;
            endcase
        end
    end

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_btn
        debounce_channel #(
            .RESET_VAL   (BTN_IDLE),
            .STABLE_TICKS(STABLE_TICKS)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .din_raw(btn_raw[i]),
            .tick   (tick),
            .run    (run),
            .prime  (prime),
            .q      (buttons[i])
        );
    end

    for (genvar i = 0; i < N_SWITCHES; i++) begin : g_sw
        debounce_channel #(
            .RESET_VAL   (SW_IDLE),
            .STABLE_TICKS(STABLE_TICKS)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .din_raw(sw_raw[i]),
            .tick   (tick),
            .run    (run),
            .prime  (prime),
            .q      (switches[i])
        );
    end

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer with TICK_DIV=4, STABLE_TICKS=3.
module tb_input_debouncer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic [9:0] sw_raw;
    logic [3:0] buttons;
    logic [9:0] switches;
    logic       ready;

    int total = 0;
    int bad   = 0;
    int n;

    input_debouncer #(
        .N_BUTTONS   (4),
        .N_SWITCHES  (10),
        .TICK_DIV    (4),
        .STABLE_TICKS(3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_raw (btn_raw),
        .sw_raw  (sw_raw),
        .buttons (buttons),
        .switches(switches),
        .ready   (ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset state, then priming on the 3rd edge
        reset   = 1'b1;
        btn_raw = 4'hF;
        sw_raw  = 10'h155;
        step(); step(); step();
        chk("rst_buttons", 32'(buttons), 32'hF);
        chk("rst_switches", 32'(switches), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            step();
            chk("prime_ready", 32'(ready), (k == 3) ? 32'h1 : 32'h0);
            chk("prime_switches", 32'(switches), (k == 3) ? 32'h155 : 32'h0);
        end
        chk("prime_buttons", 32'(buttons), 32'hF);

        // 2: button 0 press latency
        step();
        btn_raw[0] = 1'b0;
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            chk("btn0_others", 32'(buttons[3:1]), 32'h7);
            if (buttons[0] == 1'b0 && n == 0) n = k;
            if (n != 0) break;
        end
        chk("btn0_latency_ok", 32'((n >= 11) && (n <= 15)), 32'h1);
        chk("btn0_level", 32'(buttons), 32'hE);

        // 3: bouncing button 2 never qualifies
        for (int c = 0; c < 40; c++) begin
            if (c % 3 == 0) btn_raw[2] = ~btn_raw[2];
            step();
            chk("btn2_bounce", 32'(buttons[2]), 32'h1);
        end
        btn_raw[2] = 1'b1;
        for (int k = 0; k < 20; k++) step();
        chk("btn2_settled", 32'(buttons), 32'hE);

        // 4: two switches flipped together update together
        sw_raw = 10'h354;
        n = 0;
        for (int k = 1; k <= 30; k++) begin
            step();
            chk("sw_pair_atomic", 32'((switches == 10'h155) || (switches == 10'h354)), 32'h1);
            if (switches == 10'h354) begin
                n = k;
                break;
            end
        end
        chk("sw_pair_latency_ok", 32'((n >= 11) && (n <= 15)), 32'h1);
        chk("sw_pair_final", 32'(switches), 32'h354);

        // 5: reset mid-debounce discards progress; priming picks up the new level
        sw_raw = 10'h35C;
        for (int k = 0; k < 8; k++) step();
        chk("pre_rst_sw", 32'(switches), 32'h354);
        reset = 1'b1;
        #1;
        chk("mid_rst_switches", 32'(switches), 32'h0);
        chk("mid_rst_ready", 32'(ready), 32'h0);
        chk("mid_rst_buttons", 32'(buttons), 32'hF);
        step(); step();
        reset = 1'b0;

        // 6: tick cadence from reset removal, plus priming of the new level
        for (int k = 1; k <= 40; k++) begin
            step();
            chk("tick_cadence", 32'(dut.tick), (k % 4 == 3) ? 32'h1 : 32'h0);
            if (k <= 3) begin
                chk("reprime_ready", 32'(ready), (k == 3) ? 32'h1 : 32'h0);
                chk("reprime_switches", 32'(switches), (k == 3) ? 32'h35C : 32'h0);
                chk("reprime_buttons", 32'(buttons), (k == 3) ? 32'hE : 32'hF);
            end
        end
        chk("final_switches", 32'(switches), 32'h35C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
